// File: rtl/pipe_alu.sv
// rtl/pipe_alu.sv - single-stage ALU with valid/ready handshake, registered result and condition codes
module pipe_alu #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Ctrl,
    input  logic             set_cc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             OF,
    output logic [2:0]       cc
);
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_of;
    logic             sign_a;
    logic             sign_b;
    logic             sign_r;

    assign in_ready = (!out_valid || out_ready) && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign shamt    = B[SHW-1:0];

    always_comb begin
        res = '0;
        case (Ctrl)
            3'd0: res = A + B;
            3'd1: res = A - B;
            3'd2: res = A & B;
            3'd3: res = A ^ B;
            3'd4: res = A | B;
            3'd5: res = A << shamt;
            3'd6: res = A >> shamt;
            3'd7: res = $unsigned($signed(A) >>> shamt);
        endcase
    end

    // Signed overflow from operand/result signs; only add and sub can overflow.
    assign sign_a = A[WIDTH-1];
    assign sign_b = B[WIDTH-1];
    assign sign_r = res[WIDTH-1];

    always_comb begin
        res_of = 1'b0;
        if (Ctrl == 3'd0)
            res_of = (sign_a == sign_b) && (sign_r != sign_a);
        else if (Ctrl == 3'd1)
            res_of = (sign_a != sign_b) && (sign_r != sign_a);
    end

    // Flush never coincides with accept because in_ready is low under flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            O         <= '0;
            OF        <= 1'b0;
            cc        <= 3'b100;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            O         <= res;
            OF        <= res_of;
            if (set_cc)
                cc <= {(res == '0), sign_r, res_of};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipe_alu.sv
// tb/tb_pipe_alu.sv - directed and randomized self-checking bench for pipe_alu
module tb_pipe_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, set_cc, flush, out_valid, out_ready, OF;
    logic [63:0] A, B, O;
    logic [2:0]  Ctrl, cc;

    logic        in_valid8, in_ready8, set_cc8, out_valid8, out_ready8, OF8;
    logic [7:0]  A8, B8, O8;
    logic [2:0]  Ctrl8, cc8;

    int total = 0;
    int bad   = 0;

    logic        m_valid, m_of, exp_ready, acc, r_of;
    logic [63:0] m_o, r_res;
    logic [2:0]  m_cc;

    pipe_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Ctrl(Ctrl), .set_cc(set_cc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .O(O), .OF(OF), .cc(cc)
    );

    pipe_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Ctrl(Ctrl8), .set_cc(set_cc8), .flush(1'b0),
        .out_valid(out_valid8), .out_ready(out_ready8), .O(O8), .OF(OF8), .cc(cc8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic sc);
        in_valid = 1'b1;
        Ctrl     = op;
        A        = a;
        B        = b;
        set_cc   = sc;
    endtask

    // Reference: two's-complement arithmetic on a widened signed value, shifts bit by bit.
    function automatic void ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic of);
        logic signed [64:0] w;
        int amt;
        amt = int'(b[5:0]);
        r   = '0;
        of  = 1'b0;
        case (op)
            3'd0: begin w = $signed({a[63], a}) + $signed({b[63], b}); r = w[63:0]; of = (w[64] != w[63]); end
            3'd1: begin w = $signed({a[63], a}) - $signed({b[63], b}); r = w[63:0]; of = (w[64] != w[63]); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: r = a | b;
            3'd5: begin r = a; for (int i = 0; i < amt; i++) r = {r[62:0], 1'b0}; end
            3'd6: begin r = a; for (int i = 0; i < amt; i++) r = {1'b0, r[63:1]}; end
            default: begin r = a; for (int i = 0; i < amt; i++) r = {r[63], r[63:1]}; end
        endcase
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom % 6)
            0: v = 64'h0;
            1: v = 64'h7FFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Ctrl = '0; set_cc = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; A8 = '0; B8 = '0; Ctrl8 = '0; set_cc8 = 1'b0; out_ready8 = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_O", O, 0);
        chk("rst_OF", OF, 0);
        chk("rst_cc", cc, 3'b100);
        chk("rst_cc8", cc8, 3'b100);

        rst = 1'b0;
        out_ready = 1'b1;
        drive(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        #1;
        chk("first_cycle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_O", O, 64'h8000_0000_0000_0000);
        chk("add_ovf_OF", OF, 1);
        chk("add_ovf_cc", cc, 3'b011);

        drive(3'd1, 64'd5, 64'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("sub_zero_O", O, 0);
        chk("sub_zero_OF", OF, 0);
        chk("sub_zero_cc", cc, 3'b100);
        drive(3'd3, 64'd3, 64'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("xor_nocc_O", O, 0);
        chk("xor_nocc_cc", cc, 3'b100);

        drive(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        drive(3'd3, 64'd3, 64'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("cc_hold_O", O, 0);
        chk("cc_hold_cc", cc, 3'b011);

        drive(3'd7, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
        tick();
        chk("sra_O", O, 64'hF000_0000_0000_0000);
        drive(3'd6, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("srl_O", O, 64'h1000_0000_0000_0000);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_O_kept", O, 64'h1000_0000_0000_0000);

        out_ready = 1'b0;
        drive(3'd0, 64'd1, 64'd2, 1'b0);
        tick();
        drive(3'd0, 64'd10, 64'd20, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_O", O, 64'd3);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_O", O, 64'd30);
        tick();
        chk("bp_empty", out_valid, 0);

        out_ready = 1'b0;
        drive(3'd0, 64'd100, 64'd1, 1'b1);
        tick();
        drive(3'd0, 64'd5, 64'd5, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_cc", cc, 3'b000);
        chk("flush_O_kept", O, 64'd101);

        out_ready = 1'b1;
        drive(3'd0, 64'd1, 64'd1, 1'b1);
        tick();
        drive(3'd0, 64'd4, 64'd4, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_O", O, 0);
        chk("rst_mid_cc", cc, 3'b100);

        in_valid8 = 1'b1; A8 = 8'h7F; B8 = 8'h01; Ctrl8 = 3'd0; set_cc8 = 1'b1; out_ready8 = 1'b1;
        #1;
        chk("w8_in_ready", in_ready8, 1);
        tick();
        in_valid8 = 1'b0;
        chk("w8_valid", out_valid8, 1);
        chk("w8_O", O8, 8'h80);
        chk("w8_OF", OF8, 1);
        chk("w8_cc", cc8, 3'b011);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 1'b0; m_o = '0; m_of = 1'b0; m_cc = 3'b100;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid && ($urandom % 4 != 0))
                drive(3'($urandom % 8), pick(), pick(), 1'($urandom % 2));
            out_ready = ($urandom % 3 != 0);
            flush     = ($urandom % 12 == 0);
            rst       = ($urandom % 50 == 0);
            #1;
            exp_ready = (!m_valid || out_ready) && !flush && !rst;
            chk("rnd_in_ready", in_ready, exp_ready);
            acc = in_valid && exp_ready;
            ref_alu(Ctrl, A, B, r_res, r_of);
            tick();
            if (rst) begin
                m_valid = 1'b0; m_o = '0; m_of = 1'b0; m_cc = 3'b100;
            end else if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1; m_o = r_res; m_of = r_of;
                if (set_cc) m_cc = {(r_res == 64'd0), r_res[63], r_of};
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) in_valid = 1'b0;
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_O", O, m_o);
            chk("rnd_OF", OF, m_of);
            chk("rnd_cc", cc, m_cc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
